// File: rtl/valid_mask_buf.sv
// Circular buffer of per-ifmap valid masks with a registered head output.
// Build option VALID_MASK_POPCNT_EN adds a registered population count of the head mask.
module valid_mask_buf #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 1,
  localparam int DEPTH      = 1 << ADDR_WIDTH,
  localparam int PW         = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  new_if,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] valid,
  output logic [PW-1:0]         popcnt,
  output logic [ADDR_WIDTH:0]   count
);

  // Write handshake: a mask transfers on a rising edge where wr_valid and
  // wr_ready are both high; wr_ready never depends on wr_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    LIVE  = 1'b1
  } state_e;

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] valid_q, valid_d;
  logic                  push, pop, load;
  logic [ADDR_WIDTH-1:0] load_addr;

  assign wr_ready = clk_en & (count_q != FULL_CNT);
  assign push     = wr_valid & wr_ready;
  assign pop      = clk_en & new_if & (state_q == LIVE);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    state_d   = state_q;
    load      = 1'b0;
    load_addr = rd_ptr_q;
    if (clk_en) begin
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        state_d  = EMPTY;
      end else begin
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};
        case (state_q)
          EMPTY: begin
            // Only entries already in the array count: no write-to-read bypass.
            if (count_q != '0) begin
              state_d = LIVE;
              load    = 1'b1;
            end
          end
          LIVE: begin
            if (pop) begin
              if (count_q >= (ADDR_WIDTH + 1)'(2)) begin
                load      = 1'b1;
                load_addr = rd_ptr_q + 1'b1;
              end else begin
                state_d = EMPTY;
              end
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end
    valid_d = load ? mem_q[load_addr] : valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
    end
  end

  // Array is deliberately not reset or cleared by flush.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_valid = (state_q == LIVE);
  assign valid    = valid_q;
  assign count    = count_q;

`ifdef VALID_MASK_POPCNT_EN
  logic [PW-1:0] popcnt_q, popcnt_d;

  function automatic logic [PW-1:0] ones(input logic [DATA_WIDTH-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_WIDTH; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  always_comb begin
    popcnt_d = popcnt_q;
    if (load) popcnt_d = ones(mem_q[load_addr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) popcnt_q <= '0;
    else        popcnt_q <= popcnt_d;
  end

  assign popcnt = popcnt_q;
`else
  assign popcnt = '0;
`endif

endmodule

// File: tb/tb_valid_mask_buf.sv
// Directed bench for valid_mask_buf: a depth-2 instance for the main cases and a
// depth-4 instance, fed the same inputs, for the wrap-around ordering test.
module tb_valid_mask_buf;

`ifdef VALID_MASK_POPCNT_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, clk_en, flush, wr_valid, new_if;
  logic [15:0] wr_data;

  logic        wr_ready, rd_valid;
  logic [15:0] valid;
  logic [4:0]  popcnt;
  logic [1:0]  count;

  logic        wr_ready4, rd_valid4;
  logic [15:0] valid4;
  logic [4:0]  popcnt4;
  logic [2:0]  count4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [15:0] head;
  logic [15:0] vk;

  always #5 clk = ~clk;

  valid_mask_buf #(.DATA_WIDTH(16), .ADDR_WIDTH(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .new_if(new_if), .rd_valid(rd_valid), .valid(valid),
    .popcnt(popcnt), .count(count)
  );

  valid_mask_buf #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready4), .wr_data(wr_data),
    .new_if(new_if), .rd_valid(rd_valid4), .valid(valid4),
    .popcnt(popcnt4), .count(count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    new_if   = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; wr_data = '0;
    idle();
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_valid",    valid,    0);
    check("rst_popcnt",   popcnt,   0);
    check("rst_count",    count,    0);
    check("rst_wr_ready", wr_ready, 1);
    step();
    rst_n = 1'b1;
    step();

    // Single write into empty buffer: visible two edges after acceptance
    wr_valid = 1'b1; wr_data = 16'hA5A5;
    step();
    idle();
    check("w1_count",    count,    1);
    check("w1_rd_valid", rd_valid, 0);
    step();
    check("w1_live",   rd_valid, 1);
    check("w1_valid",  valid,    16'hA5A5);
    check("w1_popcnt", popcnt,   PC_EN ? 8 : 0);
    new_if = 1'b1;
    step();
    idle();
    check("w1_pop_count", count,    0);
    check("w1_pop_rdv",   rd_valid, 0);
    check("w1_pop_hold",  valid,    16'hA5A5);

    // Fill to full, then refused push alongside a pop
    wr_valid = 1'b1; wr_data = 16'h0001;
    step();
    wr_data = 16'hFFFF;
    step();
    idle();
    check("full_count",    count,    2);
    check("full_wr_ready", wr_ready, 0);
    check("full_head",     valid,    16'h0001);
    wr_valid = 1'b1; wr_data = 16'h1234; new_if = 1'b1;
    step();
    idle();
    check("fp_count",    count,    1);
    check("fp_valid",    valid,    16'hFFFF);
    check("fp_rd_valid", rd_valid, 1);
    check("fp_popcnt",   popcnt,   PC_EN ? 16 : 0);
    check("fp_wr_ready", wr_ready, 1);
    new_if = 1'b1;
    step();
    idle();
    step();
    check("fp_drain_count", count,    0);
    check("fp_no_1234",     rd_valid, 0);

    // count=1: push and pop together
    wr_valid = 1'b1; wr_data = 16'h0F0F;
    step();
    idle();
    step();
    check("c1_head", valid, 16'h0F0F);
    wr_valid = 1'b1; wr_data = 16'h00F0; new_if = 1'b1;
    step();
    idle();
    check("c1_bubble", rd_valid, 0);
    check("c1_count",  count,    1);
    step();
    check("c1_live",   rd_valid, 1);
    check("c1_valid",  valid,    16'h00F0);
    check("c1_popcnt", popcnt,   PC_EN ? 4 : 0);
    check("c1_count2", count,    1);
    new_if = 1'b1;
    step();
    idle();

    // new_if while empty, then clk_en low with a pending write
    new_if = 1'b1;
    step();
    step();
    idle();
    check("ne_count", count,    0);
    check("ne_rdv",   rd_valid, 0);
    check("ne_valid", valid,    16'h00F0);
    clk_en = 1'b0; wr_valid = 1'b1; wr_data = 16'hBEEF;
    #1;
    check("ce_wr_ready", wr_ready, 0);
    step();
    step();
    check("ce_count", count,    0);
    check("ce_rdv",   rd_valid, 0);
    clk_en = 1'b1;
    idle();

    // Flush overrides simultaneous push and pop
    wr_valid = 1'b1; wr_data = 16'h1111;
    step();
    wr_data = 16'h2222;
    step();
    check("fl_pre_count", count, 2);
    wr_data = 16'h3333; new_if = 1'b1; flush = 1'b1;
    step();
    idle();
    check("fl_count",    count,    0);
    check("fl_rdv",      rd_valid, 0);
    check("fl_wr_ready", wr_ready, 1);
    check("fl_count4",   count4,   0);
    step();
    check("fl_stay_count", count,    0);
    check("fl_stay_rdv",   rd_valid, 0);

    // Depth-4 instance: fill, then 10 push/pop pairs through the wrap
    for (int k = 0; k < 4; k++) begin
      vk = 16'(k * 16'h1357 + 16'h0101);
      wr_valid = 1'b1; wr_data = vk;
      exp_q.push_back(vk);
      step();
      check("wr4_fill_count", count4, k + 1);
    end
    idle();
    check("wr4_full_ready", wr_ready4, 0);
    head = exp_q.pop_front();
    check("wr4_head0", valid4, head);
    new_if = 1'b1;
    step();
    idle();
    check("wr4_count3", count4, 3);
    for (int k = 4; k < 14; k++) begin
      head = exp_q.pop_front();
      check("wr4_rdv",   rd_valid4, 1);
      check("wr4_order", valid4,    head);
      vk = 16'(k * 16'h1357 + 16'h0101);
      wr_valid = 1'b1; wr_data = vk; new_if = 1'b1;
      exp_q.push_back(vk);
      step();
      check("wr4_count", count4, 3);
    end
    idle();
    for (int k = 0; k < 3; k++) begin
      head = exp_q.pop_front();
      check("wr4_drain_rdv",   rd_valid4, 1);
      check("wr4_drain_order", valid4,    head);
      new_if = 1'b1;
      step();
      idle();
    end
    check("wr4_end_count", count4,    0);
    check("wr4_end_rdv",   rd_valid4, 0);

    // Asynchronous reset mid-stream
    flush = 1'b1;
    step();
    idle();
    wr_valid = 1'b1; wr_data = 16'h5A5A;
    step();
    idle();
    step();
    check("ar_pre_valid", valid, 16'h5A5A);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rd_valid", rd_valid, 0);
    check("ar_valid",    valid,    0);
    check("ar_popcnt",   popcnt,   0);
    check("ar_count",    count,    0);
    check("ar_wr_ready", wr_ready, 1);
    check("ar_valid4",   valid4,   0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
